writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter_pkg.sv | 26 ++
 rtl/writeback_arbiter_fifo.sv | 78 +++++++
 rtl/writeback_arbiter.sv | 169 ++++++++++++++++
 tb/tb_writeback_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | writeback_arbiter_pkg                                                |
// | Shared types and constants for the writeback arbiter.                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package writeback_arbiter_pkg;

    localparam int P_REG_W       = 7;
    localparam int WORD_W        = 32;
    localparam int N_WB_SRC      = 3;
    localparam int WB_FIFO_DEPTH = 2;
    localparam int N_WB_PORTS    = 2;

    typedef logic [P_REG_W-1:0] p_reg;
    typedef logic [WORD_W-1:0]  word;

    typedef struct packed {
        p_reg dest;
        word  data;
    } wb_entry;

endpackage

`default_nettype wire

// File: rtl/writeback_arbiter_fifo.sv
// +----------------------------------------------------------------------+
// | wb_fifo                                                              |
// | Synchronous FIFO of writeback entries with registered head.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module wb_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  wb_entry                      i_wr_entry,
    input  logic                         i_pop,
    output wb_entry                      o_head,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = i_push && (count_q != CNT_W'(DEPTH));
    assign do_pop  = i_pop && (count_q != '0);

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_wr_entry;
        end
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;

endmodule

`default_nettype wire

// File: rtl/writeback_arbiter.sv
// +----------------------------------------------------------------------+
// | writeback_arbiter                                                    |
// | Round-robin merge of N result sources onto two register-file ports.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int N_SRC      = N_WB_SRC,
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_valid  [N_SRC],
    output logic o_ready  [N_SRC],
    input  p_reg i_dest   [N_SRC],
    input  word  i_data   [N_SRC],
    output logic o_w_en   [N_WB_PORTS],
    output p_reg o_w_addr [N_WB_PORTS],
    output word  o_w_data [N_WB_PORTS],
    output logic o_idle
);

    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic             push     [N_SRC];
    logic             pop      [N_SRC];
    logic             full     [N_SRC];
    logic             empty    [N_SRC];
    wb_entry          wr_entry [N_SRC];
    wb_entry          head     [N_SRC];
    logic [CNT_W-1:0] count    [N_SRC];

    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0] idx;
    logic             g0_vld, g1_vld, cand_vld;
    logic [SRC_W-1:0] g0_src, g1_src, cand_src;

    logic             w_en_q   [N_WB_PORTS];
    logic             w_en_d   [N_WB_PORTS];
    p_reg             w_addr_q [N_WB_PORTS];
    p_reg             w_addr_d [N_WB_PORTS];
    word              w_data_q [N_WB_PORTS];
    word              w_data_d [N_WB_PORTS];

    // Source index reached by stepping 'off' places forward from 'base'.
    function automatic logic [SRC_W-1:0] src_at(input logic [SRC_W-1:0] base, input int off);
        int t;
        t = int'(base) + off;
        if (t >= N_SRC) begin
            t = t - N_SRC;
        end
        return SRC_W'(t);
    endfunction

    generate
        for (genvar s = 0; s < N_SRC; s++) begin : g_src
            assign o_ready[s]  = !full[s] && !i_rst;
            assign push[s]     = i_valid[s] && o_ready[s] && (i_dest[s] != '0);
            assign wr_entry[s] = '{dest: i_dest[s], data: i_data[s]};
            assign pop[s]      = (g0_vld && (g0_src == SRC_W'(s)))
                              || (g1_vld && (g1_src == SRC_W'(s)));

            wb_fifo #(
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk        (i_clk),
                .rst        (i_rst),
                .i_push     (push[s]),
                .i_wr_entry (wr_entry[s]),
                .i_pop      (pop[s]),
                .o_head     (head[s]),
                .o_full     (full[s]),
                .o_empty    (empty[s]),
                .o_count    (count[s])
            );
        end
    endgenerate

    // Port 1 searches onward from the port-0 winner; everything between
    // rr_ptr and that winner is already known to be empty.
    always_comb begin
        g0_vld   = 1'b0;
        g0_src   = '0;
        cand_vld = 1'b0;
        cand_src = '0;
        idx      = '0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = src_at(rr_ptr_q, k);
            if (!g0_vld && !empty[idx]) begin
                g0_vld = 1'b1;
                g0_src = idx;
            end
        end
        for (int j = 1; j < N_SRC; j++) begin
            idx = src_at(g0_src, j);
            if (g0_vld && !cand_vld && !empty[idx]) begin
                cand_vld = 1'b1;
                cand_src = idx;
            end
        end
        g1_vld = cand_vld && (head[cand_src].dest != head[g0_src].dest);
        g1_src = cand_src;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (g1_vld) begin
            rr_ptr_d = src_at(g1_src, 1);
        end else if (g0_vld) begin
            rr_ptr_d = src_at(g0_src, 1);
        end
    end

    always_comb begin
        for (int p = 0; p < N_WB_PORTS; p++) begin
            w_en_d[p]   = 1'b0;
            w_addr_d[p] = w_addr_q[p];
            w_data_d[p] = w_data_q[p];
        end
        if (g0_vld) begin
            w_en_d[0]   = 1'b1;
            w_addr_d[0] = head[g0_src].dest;
            w_data_d[0] = head[g0_src].data;
        end
        if (g1_vld) begin
            w_en_d[1]   = 1'b1;
            w_addr_d[1] = head[g1_src].dest;
            w_data_d[1] = head[g1_src].data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr_q <= '0;
            for (int p = 0; p < N_WB_PORTS; p++) begin
                w_en_q[p]   <= 1'b0;
                w_addr_q[p] <= '0;
                w_data_q[p] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int p = 0; p < N_WB_PORTS; p++) begin
                w_en_q[p]   <= w_en_d[p];
                w_addr_q[p] <= w_addr_d[p];
                w_data_q[p] <= w_data_d[p];
            end
        end
    end

    always_comb begin
        o_idle = !w_en_q[0] && !w_en_q[1];
        for (int s = 0; s < N_SRC; s++) begin
            if (count[s] != '0) begin
                o_idle = 1'b0;
            end
        end
    end

    assign o_w_en   = w_en_q;
    assign o_w_addr = w_addr_q;
    assign o_w_data = w_data_q;

endmodule

`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_writeback_arbiter                                                 |
// | Directed and random checks against a queue-based reference model.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    localparam int N = N_WB_SRC;
    localparam int D = WB_FIFO_DEPTH;

    logic clk;
    logic rst;
    logic valid  [N];
    logic ready  [N];
    p_reg dest   [N];
    word  data   [N];
    logic w_en   [N_WB_PORTS];
    p_reg w_addr [N_WB_PORTS];
    word  w_data [N_WB_PORTS];
    logic idle;

    writeback_arbiter dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (valid),
        .o_ready  (ready),
        .i_dest   (dest),
        .i_data   (data),
        .o_w_en   (w_en),
        .o_w_addr (w_addr),
        .o_w_data (w_data),
        .o_idle   (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // stimulus for the next cycle
    logic st_rst;
    logic st_valid [N];
    p_reg st_dest  [N];
    word  st_data  [N];

    // reference model state
    wb_entry mq [N][$];
    int      m_rr;
    logic    m_ready [N];
    logic    m_hs    [N];
    logic    m_idle;
    logic    e_en    [N_WB_PORTS];
    p_reg    e_addr  [N_WB_PORTS];
    word     e_data  [N_WB_PORTS];

    logic    collect_src1;
    logic    ready1_low_seen;
    word     seen1 [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        st_rst = 1'b0;
        for (int s = 0; s < N; s++) begin
            st_valid[s] = 1'b0;
            st_dest[s]  = '0;
            st_data[s]  = '0;
        end
    endtask

    // One clock of the reference behaviour, from the current queues and stimulus.
    task automatic model_step();
        int order[$];
        int g0;
        int g1;
        int last;
        m_idle = (e_en[0] == 1'b0) && (e_en[1] == 1'b0);
        for (int s = 0; s < N; s++) begin
            if (mq[s].size() != 0) m_idle = 1'b0;
            m_ready[s] = !st_rst && (mq[s].size() < D);
            m_hs[s]    = st_valid[s] && m_ready[s];
        end
        if (st_rst) begin
            for (int s = 0; s < N; s++) mq[s].delete();
            m_rr = 0;
            for (int p = 0; p < N_WB_PORTS; p++) begin
                e_en[p]   = 1'b0;
                e_addr[p] = '0;
                e_data[p] = '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (mq[(m_rr + k) % N].size() != 0) order.push_back((m_rr + k) % N);
            end
            e_en[0] = 1'b0;
            e_en[1] = 1'b0;
            g1 = -1;
            if (order.size() > 0) begin
                g0 = order[0];
                last = g0;
                e_en[0]   = 1'b1;
                e_addr[0] = mq[g0][0].dest;
                e_data[0] = mq[g0][0].data;
                if (order.size() > 1 && mq[order[1]][0].dest != mq[g0][0].dest) begin
                    g1 = order[1];
                    last = g1;
                    e_en[1]   = 1'b1;
                    e_addr[1] = mq[g1][0].dest;
                    e_data[1] = mq[g1][0].data;
                end
                m_rr = (last + 1) % N;
                void'(mq[g0].pop_front());
                if (g1 >= 0) void'(mq[g1].pop_front());
            end
            for (int s = 0; s < N; s++) begin
                if (m_hs[s] && st_dest[s] != 0) mq[s].push_back('{dest: st_dest[s], data: st_data[s]});
            end
        end
    endtask

    task automatic tick();
        rst = st_rst;
        for (int s = 0; s < N; s++) begin
            valid[s] = st_valid[s];
            dest[s]  = st_dest[s];
            data[s]  = st_data[s];
        end
        model_step();
        #1;
        for (int s = 0; s < N; s++) chk($sformatf("ready%0d", s), 64'(ready[s]), 64'(m_ready[s]));
        if (!ready[1]) ready1_low_seen = 1'b1;
        chk("idle", 64'(idle), 64'(m_idle));
        @(posedge clk);
        #1;
        for (int p = 0; p < N_WB_PORTS; p++) begin
            chk($sformatf("w_en%0d", p), 64'(w_en[p]), 64'(e_en[p]));
            chk($sformatf("w_addr%0d", p), 64'(w_addr[p]), 64'(e_addr[p]));
            chk($sformatf("w_data%0d", p), 64'(w_data[p]), 64'(e_data[p]));
            if (collect_src1 && w_en[p] && w_data[p][31:16] == 16'h1111) seen1.push_back(w_data[p]);
        end
    endtask

    task automatic do_reset();
        set_idle();
        st_rst = 1'b1;
        tick();
        set_idle();
    endtask

    initial begin
        int cnt;
        collect_src1    = 1'b0;
        ready1_low_seen = 1'b0;
        m_rr = 0;
        for (int p = 0; p < N_WB_PORTS; p++) begin
            e_en[p] = 1'b0; e_addr[p] = '0; e_data[p] = '0;
        end
        set_idle();
        rst = 1'b1;
        for (int s = 0; s < N; s++) begin
            valid[s] = 1'b0; dest[s] = '0; data[s] = '0;
        end
        repeat (2) @(posedge clk);
        #1;

        // reset state
        do_reset();
        do_reset();
        chk("rst_w_en0", 64'(w_en[0]), 64'd0);
        chk("rst_w_addr1", 64'(w_addr[1]), 64'd0);

        // single result, two-cycle latency
        st_valid[0] = 1'b1; st_dest[0] = 7'd5; st_data[0] = 32'hDEADBEEF;
        tick();
        set_idle();
        tick();
        chk("single_en0", 64'(w_en[0]), 64'd1);
        chk("single_addr0", 64'(w_addr[0]), 64'd5);
        chk("single_data0", 64'(w_data[0]), 64'hDEADBEEF);
        chk("single_en1", 64'(w_en[1]), 64'd0);
        tick();

        // three-way contention from rr_ptr=0
        do_reset();
        for (int s = 0; s < N; s++) begin
            st_valid[s] = 1'b1; st_dest[s] = 7'(s + 1); st_data[s] = 32'hC0 + 32'(s);
        end
        tick();
        set_idle();
        tick();
        chk("cont_addr0", 64'(w_addr[0]), 64'd1);
        chk("cont_addr1", 64'(w_addr[1]), 64'd2);
        chk("cont_en1", 64'(w_en[1]), 64'd1);
        tick();
        chk("cont2_addr0", 64'(w_addr[0]), 64'd3);
        chk("cont2_en1", 64'(w_en[1]), 64'd0);

        // backpressure on src1 with src0/src2 busy
        do_reset();
        collect_src1    = 1'b1;
        ready1_low_seen = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20 && cnt < 4; i++) begin
            st_valid[0] = 1'b1; st_dest[0] = 7'(10 + i % 4); st_data[0] = 32'h00A0_0000 + 32'(i);
            st_valid[2] = 1'b1; st_dest[2] = 7'(30 + i % 4); st_data[2] = 32'h00C0_0000 + 32'(i);
            st_valid[1] = 1'b1; st_dest[1] = 7'(20 + cnt);    st_data[1] = 32'h1111_0000 + 32'(cnt);
            tick();
            if (m_hs[1]) cnt++;
        end
        set_idle();
        repeat (8) tick();
        chk("bp_ready1_dropped", 64'(ready1_low_seen), 64'd1);
        chk("bp_count", 64'(seen1.size()), 64'd4);
        for (int i = 0; i < 4 && i < seen1.size(); i++) begin
            chk($sformatf("bp_order%0d", i), 64'(seen1[i]), 64'h1111_0000 + 64'(i));
        end
        collect_src1 = 1'b0;

        // zero destination is swallowed
        do_reset();
        st_valid[2] = 1'b1; st_dest[2] = '0; st_data[2] = 32'h0BAD_F00D;
        tick();
        set_idle();
        repeat (3) tick();
        chk("zero_idle", 64'(idle), 64'd1);
        chk("zero_en0", 64'(w_en[0]), 64'd0);

        // same-dest conflict serialises in grant order
        do_reset();
        st_valid[0] = 1'b1; st_dest[0] = 7'd9; st_data[0] = 32'hAAAA_0000;
        st_valid[1] = 1'b1; st_dest[1] = 7'd9; st_data[1] = 32'hBBBB_0000;
        tick();
        set_idle();
        tick();
        chk("conf_data0", 64'(w_data[0]), 64'hAAAA_0000);
        chk("conf_en1", 64'(w_en[1]), 64'd0);
        tick();
        chk("conf2_en0", 64'(w_en[0]), 64'd1);
        chk("conf2_data0", 64'(w_data[0]), 64'hBBBB_0000);

        // reset mid-stream with four entries queued
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < N; s++) begin
                st_valid[s] = 1'b1; st_dest[s] = 7'(1 + s + 3 * r); st_data[s] = 32'h3600 + 32'(s + 3 * r);
            end
            tick();
        end
        do_reset();
        rst = 1'b0;
        #1;
        for (int s = 0; s < N; s++) chk($sformatf("mid_ready%0d", s), 64'(ready[s]), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_en0", 64'(w_en[0]), 64'd0);
            chk("mid_en1", 64'(w_en[1]), 64'd0);
            chk("mid_idle", 64'(idle), 64'd1);
        end

        // random traffic
        for (int i = 0; i < 400; i++) begin
            st_rst = ($urandom_range(0, 49) == 0);
            for (int s = 0; s < N; s++) begin
                st_valid[s] = ($urandom_range(0, 99) < 60);
                st_dest[s]  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 6));
                st_data[s]  = $urandom;
            end
            tick();
        end
        set_idle();
        repeat (8) tick();
        chk("final_idle", 64'(idle), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
